// File: rtl/imem_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader_if
//  Description : Byte-stream input (valid/ready) and instruction-memory write
//                port bundle for the program loader.
//                master = stream source / memory side, slave = loader.
//  Revision    : 1.0  initial release
// ============================================================================
interface imem_loader_if;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output wr_en,
        output wr_addr,
        output wr_data
    );
endinterface
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader
//  Description : Serial program loader. Parses a framed byte stream
//                (count, big-endian words, XOR checksum), writes each word
//                to instruction memory at consecutive word addresses and
//                holds the CPU while the frame is in progress.
//  Revision    : 1.0  initial release
// ============================================================================
module imem_loader #(
    parameter int          MAX_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  wire logic     clk,
    input  wire logic     rst,
    input  wire logic     start,
    imem_loader_if.slave  bus,
    output logic          cpu_hold,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HDR_HI = 3'd1,
        S_HDR_LO = 3'd2,
        S_DATA   = 3'd3,
        S_CHK    = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    localparam logic [16:0] c_max_words = 17'(MAX_WORDS);

    state_t      r_state;
    logic        r_in_ready;
    logic        r_busy;
    logic        r_done;
    logic        r_err;
    logic        r_wr_en;
    logic [31:0] r_wr_addr;
    logic [31:0] r_wr_data;
    logic [15:0] r_count;
    logic [15:0] r_word_idx;
    logic [1:0]  r_byte_cnt;
    logic [7:0]  r_xor;
    logic [23:0] r_asm;

    logic        w_xfer;
    logic [15:0] w_count;
    logic        w_too_big;
    logic [31:0] w_word;
    logic [31:0] w_addr;
    logic        w_last_word;

    // A byte moves only when the loader is ready; ready is purely registered
    assign w_xfer      = bus.in_valid && r_in_ready;
    assign w_count     = {r_count[15:8], bus.in_data};
    assign w_too_big   = {1'b0, w_count} > c_max_words;
    assign w_word      = {r_asm, bus.in_data};
    // Address wraps naturally in 32 bits
    assign w_addr      = BASE_ADDR + {14'd0, r_word_idx, 2'b00};
    assign w_last_word = ({1'b0, r_word_idx} + 17'd1) == {1'b0, r_count};

    // Frame parser, word assembler and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= 32'd0;
            r_wr_data  <= 32'd0;
            r_count    <= 16'd0;
            r_word_idx <= 16'd0;
            r_byte_cnt <= 2'd0;
            r_xor      <= 8'd0;
            r_asm      <= 24'd0;
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        r_state    <= S_HDR_HI;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_err      <= 1'b0;
                        r_word_idx <= 16'd0;
                        r_byte_cnt <= 2'd0;
                        r_xor      <= 8'd0;
                    end
                end
                S_HDR_HI: begin
                    if (w_xfer) begin
                        r_count[15:8] <= bus.in_data;
                        r_state       <= S_HDR_LO;
                    end
                end
                S_HDR_LO: begin
                    if (w_xfer) begin
                        r_count[7:0] <= bus.in_data;
                        if (w_too_big) begin
                            r_state    <= S_ERR;
                            r_in_ready <= 1'b0;
                            r_busy     <= 1'b0;
                            r_err      <= 1'b1;
                        end else if (w_count == 16'd0) begin
                            r_state <= S_CHK;
                        end else begin
                            r_state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (w_xfer) begin
                        r_asm      <= w_word[23:0];
                        r_xor      <= r_xor ^ bus.in_data;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            r_wr_en    <= 1'b1;
                            r_wr_addr  <= w_addr;
                            r_wr_data  <= w_word;
                            r_word_idx <= r_word_idx + 16'd1;
                            if (w_last_word) begin
                                r_state <= S_CHK;
                            end
                        end
                    end
                end
                S_CHK: begin
                    if (w_xfer) begin
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b0;
                        if (bus.in_data == r_xor) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_ERR;
                            r_err   <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_in_ready <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready = r_in_ready;
    assign bus.wr_en    = r_wr_en;
    assign bus.wr_addr  = r_wr_addr;
    assign bus.wr_data  = r_wr_data;
    assign busy         = r_busy;
    assign cpu_hold     = r_busy;
    assign done         = r_done;
    assign err          = r_err;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_loader
//  Description : Scoreboard bench for imem_loader. Two instances (base 0 and
//                base 0xFFFF_FFFC) receive the same stream; expected writes
//                are queued per instance and popped by write monitors.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_imem_loader;

    localparam logic [31:0] BASE0 = 32'h0000_0000;
    localparam logic [31:0] BASE1 = 32'hFFFF_FFFC;
    localparam int          MAXW  = 1024;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       start    = 1'b0;
    logic [7:0] tb_data  = 8'h00;
    logic       tb_valid = 1'b0;

    logic hold0, busy0, done0, err0;
    logic hold1, busy1, done1, err1;

    imem_loader_if bus0 ();
    imem_loader_if bus1 ();

    assign bus0.in_data  = tb_data;
    assign bus0.in_valid = tb_valid;
    assign bus1.in_data  = tb_data;
    assign bus1.in_valid = tb_valid;

    imem_loader #(.MAX_WORDS(MAXW), .BASE_ADDR(BASE0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .bus(bus0),
        .cpu_hold(hold0), .busy(busy0), .done(done0), .err(err0)
    );

    imem_loader #(.MAX_WORDS(MAXW), .BASE_ADDR(BASE1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .bus(bus1),
        .cpu_hold(hold1), .busy(busy1), .done(done1), .err(err1)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [63:0] q0[$];
    logic [63:0] q1[$];
    logic [31:0] fw[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Write monitors: every wr_en cycle must match the head of the queue
    always @(negedge clk) begin
        if (!rst && bus0.wr_en === 1'b1) begin
            if (q0.size() == 0) begin
                checks++; errors++;
                $display("FAIL dut0 unexpected write addr=%h data=%h", bus0.wr_addr, bus0.wr_data);
            end else begin
                logic [63:0] e;
                e = q0.pop_front();
                chk("dut0 wr_addr", bus0.wr_addr, e[63:32]);
                chk("dut0 wr_data", bus0.wr_data, e[31:0]);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && bus1.wr_en === 1'b1) begin
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL dut1 unexpected write addr=%h data=%h", bus1.wr_addr, bus1.wr_data);
            end else begin
                logic [63:0] e;
                e = q1.pop_front();
                chk("dut1 wr_addr", bus1.wr_addr, e[63:32]);
                chk("dut1 wr_data", bus1.wr_data, e[31:0]);
            end
        end
    end

    task automatic check_idle_outputs(input string tag);
        chk({tag, " in_ready0"}, 32'(bus0.in_ready), 32'd0);
        chk({tag, " wr_en0"},    32'(bus0.wr_en),    32'd0);
        chk({tag, " wr_addr0"},  bus0.wr_addr,       32'd0);
        chk({tag, " wr_data0"},  bus0.wr_data,       32'd0);
        chk({tag, " hold0"},     32'(hold0),         32'd0);
        chk({tag, " busy0"},     32'(busy0),         32'd0);
        chk({tag, " done0"},     32'(done0),         32'd0);
        chk({tag, " err0"},      32'(err0),          32'd0);
        chk({tag, " wr_addr1"},  bus1.wr_addr,       32'd0);
        chk({tag, " busy1"},     32'(busy1),         32'd0);
    endtask

    // Called at posedge+1; returns at posedge+1 right after the transfer edge
    task automatic send_byte(input logic [7:0] b, input int gap_pct);
        bit ok;
        int g;
        g = 0;
        while (g < 5 && $urandom_range(99) < gap_pct) begin
            tb_valid = 1'b0;
            tb_data  = 8'($urandom);
            @(posedge clk); #1;
            g++;
        end
        tb_valid = 1'b1;
        tb_data  = b;
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus0.in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL byte timeout in_ready=%b required=1", bus0.in_ready);
        end
        @(posedge clk); #1;
        tb_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // chk_mode: 0 = correct checksum, 1 = chk_val as given, 2 = corrupted
    task automatic run_frame(input int n, input int chk_mode, input logic [7:0] chk_val,
                             input int gap_pct, input bit mid_start, input string tag);
        logic [7:0]  x;
        logic [7:0]  sent;
        logic [31:0] w;
        logic [15:0] n16;
        bit          too_big;
        bit          good;
        x       = 8'h00;
        n16     = 16'(n);
        too_big = (n > MAXW);
        if (!too_big) begin
            for (int i = 0; i < n; i++) begin
                w = fw[i];
                x = x ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
                q0.push_back({BASE0 + 32'(4 * i), w});
                q1.push_back({BASE1 + 32'(4 * i), w});
            end
        end
        case (chk_mode)
            0:       sent = x;
            1:       sent = chk_val;
            default: sent = x ^ 8'($urandom_range(1, 255));
        endcase
        good = !too_big && (sent == x);

        @(posedge clk); #1;
        pulse_start();
        @(negedge clk);
        chk({tag, " busy after start"},  32'(busy0),         32'd1);
        chk({tag, " hold after start"},  32'(hold0),         32'd1);
        chk({tag, " ready after start"}, 32'(bus0.in_ready), 32'd1);
        chk({tag, " done cleared"},      32'(done0),         32'd0);
        chk({tag, " err cleared"},       32'(err1),          32'd0);
        @(posedge clk); #1;

        send_byte(n16[15:8], gap_pct);
        send_byte(n16[7:0], gap_pct);
        if (!too_big) begin
            for (int i = 0; i < n; i++) begin
                w = fw[i];
                for (int j = 3; j >= 0; j--) begin
                    send_byte(w[8*j +: 8], gap_pct);
                    if (mid_start && i == 0 && j == 1) begin
                        pulse_start();
                    end
                end
            end
            send_byte(sent, gap_pct);
        end

        chk({tag, " done0"},     32'(done0),         32'(good));
        chk({tag, " err0"},      32'(err0),          32'(!good));
        chk({tag, " done1"},     32'(done1),         32'(good));
        chk({tag, " err1"},      32'(err1),          32'(!good));
        chk({tag, " busy end"},  32'(busy0),         32'd0);
        chk({tag, " hold end"},  32'(hold1),         32'd0);
        chk({tag, " ready end"}, 32'(bus0.in_ready), 32'd0);
        @(negedge clk);
        chk({tag, " q0 drained"}, 32'(q0.size()), 32'd0);
        chk({tag, " q1 drained"}, 32'(q1.size()), 32'd0);
        q0.delete();
        q1.delete();
    endtask

    initial begin
        logic [31:0] w;
        // Reset state
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;

        // Basic frame, contiguous
        fw.delete(); fw.push_back(32'h0400_0001); fw.push_back(32'hFFFF_FFFF);
        run_frame(2, 1, 8'h05, 0, 1'b0, "basic");

        // Same frame with gaps
        run_frame(2, 1, 8'h05, 50, 1'b0, "gaps");

        // Bad checksum, then recovery
        fw.delete(); fw.push_back(32'h1234_5678);
        run_frame(1, 1, 8'h00, 0, 1'b0, "badchk");
        run_frame(1, 1, 8'h08, 20, 1'b0, "recover");

        // Oversized count and empty frame
        fw.delete();
        run_frame(MAXW + 1, 0, 8'h00, 0, 1'b0, "oversize");
        run_frame(0, 1, 8'h00, 0, 1'b0, "empty");

        // Start while busy is ignored
        fw.delete(); fw.push_back(32'hDEAD_BEEF); fw.push_back(32'h0BAD_F00D);
        run_frame(2, 0, 8'h00, 10, 1'b1, "midstart");

        // Stray valid bytes in DONE are ignored
        tb_valid = 1'b1;
        repeat (4) begin
            tb_data = 8'($urandom);
            @(negedge clk);
            chk("stray ready", 32'(bus0.in_ready), 32'd0);
            @(posedge clk); #1;
        end
        tb_valid = 1'b0;

        // Asynchronous reset after 6 data bytes
        fw.delete(); fw.push_back(32'hA1B2_C3D4); fw.push_back(32'h5566_7788);
        q0.push_back({BASE0, fw[0]});
        q1.push_back({BASE1, fw[0]});
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        for (int j = 0; j < 6; j++) begin
            w = fw[j / 4];
            send_byte(w[8*(3 - (j % 4)) +: 8], 0);
        end
        #2 rst = 1'b1;
        #1 check_idle_outputs("asyncrst");
        chk("asyncrst q0 drained", 32'(q0.size()), 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("rst wr_en", 32'(bus0.wr_en), 32'd0);
        end
        rst = 1'b0;
        q0.delete();
        q1.delete();

        // Randomized frames
        for (int f = 0; f < 20; f++) begin
            int n;
            n = $urandom_range(0, 6);
            fw.delete();
            for (int i = 0; i < n; i++) fw.push_back($urandom);
            run_frame(n, ($urandom_range(3) == 0) ? 2 : 0, 8'h00,
                      $urandom_range(0, 50), 1'b0, "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/imem_loader.md
# imem_loader

Serial program loader that fills the instruction memory before the pipeline runs. It accepts a framed byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words. Each word is written through a single-port write interface at consecutive word-aligned byte addresses, matching the PC's +4 stepping. It holds the processor in reset while loading and reports completion or checksum/length errors.

## Interface
Parameters:
- MAX_WORDS, 1024: instruction memory depth in words; larger frames are rejected.
- BASE_ADDR, 32'h0: byte address of the first written word.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  reset, asynchronous and active-high.
- start  input  1  one-cycle request to begin a load; honoured only in IDLE, DONE or ERR.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader accepts a byte this cycle.
- wr_en  output  1  instruction-memory write strobe, one cycle per word.
- wr_addr  output  32  byte address of the word being written.
- wr_data  output  32  instruction word.
- cpu_hold  output  1  holds the pipeline (drives PC reset) while loading.
- busy  output  1  frame in progress.
- done  output  1  last frame completed cleanly; sticky until next start or reset.
- err  output  1  last frame failed; sticky until next start or reset.

## Operation
- Frame format: CNT_HI, CNT_LO (16-bit word count N), then N×4 data bytes (MSB first per word), then one CHK byte equal to the XOR of all data bytes.
- A byte transfers on a rising edge where in_valid && in_ready.
- States:
  - IDLE: no activity. start → HDR_HI.
  - HDR_HI: on transfer, latch count[15:8] → HDR_LO.
  - HDR_LO: on transfer, latch count[7:0].
    - N > MAX_WORDS → ERR.
    - N = 0 → CHK.
    - Otherwise → DATA.
  - DATA: shift bytes into a 32-bit assembly register (new byte enters bits [7:0]); 2-bit byte counter; running XOR accumulates every data byte.
    - On the 4th byte, issue the write (see Timing) and increment the word index.
    - After word N-1 → CHK.
  - CHK: on transfer, compare the byte to the running XOR. Equal → DONE, else → ERR.
  - DONE / ERR: in_ready=0. start → HDR_HI, clearing done, err, word index, byte counter and XOR.
- wr_addr = BASE_ADDR + (word_index << 2), 32-bit; wraps modulo 2^32.
- in_ready = 1 in HDR_HI, HDR_LO, DATA and CHK; 0 otherwise.
- busy = 1 in HDR_HI..CHK. cpu_hold = busy.
- start is ignored while busy. in_valid outside busy states is ignored.
- Memory words written before an ERR stay written; no rollback.

## Timing
- Reset values: state IDLE, in_ready 0, wr_en 0, wr_addr 0, wr_data 0, cpu_hold 0, busy 0, done 0, err 0, all counters and XOR 0.
- start sampled high in an allowed state → busy, cpu_hold and in_ready high from the next cycle.
- wr_en, wr_addr and wr_data are registered. They are valid in the cycle after the edge that accepted the word's 4th byte. wr_en is high exactly one cycle; wr_addr and wr_data hold until the next write.
- Full throughput: one byte per cycle with no bubbles. in_ready does not depend combinationally on in_valid.
- done/err rise in the cycle after the CHK-byte (or bad CNT_LO) transfer. busy and cpu_hold fall in that same cycle.
- Minimum frame (N=0) takes 3 transfer cycles.
- Asynchronous rst mid-frame: immediate return to reset values. wr_en is deasserted without completing a partial word.

## Test plan
- Load N=2, words 32'h0400_0001 and 32'hFFFF_FFFF, CHK = 8'h05, contiguous valid → wr_en at addresses 0x0 and 0x4 with those data; done=1, err=0; cpu_hold high for the frame only.
- Same frame with random in_valid gaps → identical writes and addresses; no byte lost or duplicated.
- N=1, word 32'h1234_5678, wrong CHK 8'h00 (correct value is 8'h08) → one write at 0x0; err=1, done=0; subsequent start with a good frame clears err and sets done.
- N=MAX_WORDS+1 (16'h0401) → err after CNT_LO, no wr_en pulse, in_ready drops. N=0 with CHK=8'h00 → done, no writes.
- Assert rst after 6 data bytes → all outputs return to reset values asynchronously; the partial second word is never written.
- Pulse start while busy → ignored; frame completes normally. BASE_ADDR=32'hFFFF_FFFC, N=2 → addresses 0xFFFF_FFFC then 0x0000_0000.
